// File: rtl/aurora_tx_arbiter_pkg.sv
// Shared types and constants for the Aurora TX frame arbiter.
// Lane clock ratios are system clocks per accepted word in each lane mode.
package aurora_tx_arbiter_pkg;

   localparam int unsigned AXI_DATA_SIZE = 32;
   localparam logic [3:0] SYS_TO_SINGLE_LINE_CLK_RATIO = 4'd4;
   localparam logic [3:0] SYS_TO_MULTI_LINE_CLK_RATIO = 4'd2;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_SEND,
      ARB_GAP
   } arb_state_e;

   function automatic logic [3:0] lane_ratio(input logic single);
      return single ? SYS_TO_SINGLE_LINE_CLK_RATIO : SYS_TO_MULTI_LINE_CLK_RATIO;
   endfunction

endpackage

// File: rtl/aurora_tx_arbiter_if.sv
// Requester-side AXI-stream bundle: N_REQ sources sharing one arbiter.
interface aurora_tx_arbiter_if #(
   parameter int unsigned N_REQ = 4
);
   import aurora_tx_arbiter_pkg::*;

   logic [N_REQ-1:0]         s_valid;
   logic [N_REQ-1:0]         s_last;
   logic [AXI_DATA_SIZE-1:0] s_data [N_REQ];
   logic [N_REQ-1:0]         s_ready;

   modport master (
      output s_valid,
      output s_last,
      output s_data,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_last,
      input  s_data,
      output s_ready
   );

endinterface

// File: rtl/aurora_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set bit of req after ptr, wrapping mod N_REQ.
module rr_pick #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned IW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic             found,
   output logic [IW-1:0]    idx
);

   logic [IW-1:0] cand;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      // Walk from the farthest candidate inward so the nearest one after ptr wins.
      for (int unsigned k = N_REQ; k > 0; k--) begin
         cand = IW'((32'(ptr) + k) % N_REQ);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/aurora_tx_arbiter.sv
// Frame-level round-robin arbiter feeding the single Aurora TX framing path,
// pacing one word per lane clock ratio and inserting an inter-frame gap.
module aurora_tx_arbiter
   import aurora_tx_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ      = 4,
   parameter int unsigned IFG_CYCLES = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     single_lane_in,
   aurora_tx_arbiter_if.slave       src,
   output logic                     axi_valid,
   output logic                     axi_last,
   output logic [AXI_DATA_SIZE-1:0] axi_data,
   output logic                     single_lane,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic                     busy
);

   localparam int unsigned IW = $clog2(N_REQ);
   localparam int unsigned GW = $clog2(IFG_CYCLES);

   arb_state_e       state;
   logic [IW-1:0]    rr_ptr;
   logic [3:0]       beat_cnt;
   logic [GW-1:0]    gap_cnt;
   logic [3:0]       ratio;
   logic             pick_found;
   logic [IW-1:0]    pick_idx;
   logic             beat_start;
   logic             frame_done;
   logic [N_REQ-1:0] ready;

   rr_pick #(
      .N_REQ (N_REQ),
      .IW    (IW)
   ) u_rr_pick (
      .req   (src.s_valid),
      .ptr   (rr_ptr),
      .found (pick_found),
      .idx   (pick_idx)
   );

   assign ratio      = lane_ratio(single_lane);
   assign beat_start = (state == ARB_SEND) && (beat_cnt == 4'd0);
   // The last word has been on the bus a full beat period once the next period begins.
   assign frame_done = beat_start && axi_last;
   assign busy       = (state != ARB_IDLE);

   always_comb begin
      ready = '0;
      if (beat_start && !frame_done) begin
         ready[grant_id] = 1'b1;
      end
   end

   assign src.s_ready = ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ARB_IDLE;
         rr_ptr      <= IW'(N_REQ - 1);
         grant_id    <= '0;
         single_lane <= 1'b0;
         beat_cnt    <= '0;
         gap_cnt     <= '0;
         axi_valid   <= 1'b0;
         axi_last    <= 1'b0;
         axi_data    <= '0;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (pick_found) begin
                  grant_id    <= pick_idx;
                  single_lane <= single_lane_in;
                  beat_cnt    <= '0;
                  state       <= ARB_SEND;
               end
            end
            ARB_SEND: begin
               if (frame_done) begin
                  rr_ptr    <= grant_id;
                  gap_cnt   <= '0;
                  beat_cnt  <= '0;
                  axi_valid <= 1'b0;
                  axi_last  <= 1'b0;
                  axi_data  <= '0;
                  state     <= ARB_GAP;
               end else begin
                  beat_cnt <= (beat_cnt == ratio - 4'd1) ? 4'd0 : beat_cnt + 4'd1;
                  if (beat_start) begin
                     // A missing word leaves a silent beat; the frame itself carries on.
                     if (src.s_valid[grant_id]) begin
                        axi_valid <= 1'b1;
                        axi_last  <= src.s_last[grant_id];
                        axi_data  <= src.s_data[grant_id];
                     end else begin
                        axi_valid <= 1'b0;
                        axi_last  <= 1'b0;
                        axi_data  <= '0;
                     end
                  end
               end
            end
            ARB_GAP: begin
               if (gap_cnt == GW'(IFG_CYCLES - 1)) begin
                  state <= ARB_IDLE;
               end else begin
                  gap_cnt <= gap_cnt + 1'b1;
               end
            end
            default: state <= ARB_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aurora_tx_arbiter.sv
// Bench for aurora_tx_arbiter: queued frames per requester, a frame-order model
// and a cycle monitor checking pacing, gaps, grants and handshakes.
module tb_aurora_tx_arbiter;

   localparam int N        = 4;
   localparam int IFG      = 8;
   localparam int R_MULTI  = 2;
   localparam int R_SINGLE = 4;

   typedef struct {
      logic [31:0] data;
      logic        last;
      int          stall;
   } word_t;

   typedef struct {
      int          src;
      logic [31:0] data;
      logic        last;
      logic        lane;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        single_lane_in = 1'b0;
   logic        axi_valid;
   logic        axi_last;
   logic [31:0] axi_data;
   logic        single_lane;
   logic [1:0]  grant_id;
   logic        busy;

   word_t      srcq [N][$];
   int         stall_left [N];
   logic [N-1:0] acc;
   int         model_ptr;
   int         n_cmp  = 0;
   int         n_fail = 0;

   aurora_tx_arbiter_if #(.N_REQ(N)) bus ();

   aurora_tx_arbiter #(
      .N_REQ      (N),
      .IFG_CYCLES (IFG)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .single_lane_in (single_lane_in),
      .src            (bus.slave),
      .axi_valid      (axi_valid),
      .axi_last       (axi_last),
      .axi_data       (axi_data),
      .single_lane    (single_lane),
      .grant_id       (grant_id),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic apply_reset();
      rst = 1'b1;
      single_lane_in = 1'b0;
      bus.s_valid = '0;
      bus.s_last  = '0;
      for (int i = 0; i < N; i++) bus.s_data[i] = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_ptr = N - 1;
   endtask

   task automatic add_frame(input int r, input int nw, input int st_idx, input int st_len);
      word_t w;
      for (int k = 0; k < nw; k++) begin
         w.data  = $urandom;
         w.last  = (k == nw - 1);
         w.stall = (k == st_idx && k > 0) ? st_len : 0;
         srcq[r].push_back(w);
      end
   endtask

   // Retire accepted words, then present each source's next word (or idle junk).
   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (acc[i]) begin
            srcq[i].delete(0);
            if (srcq[i].size() > 0) stall_left[i] = srcq[i][0].stall;
         end
         if (srcq[i].size() > 0 && stall_left[i] == 0) begin
            bus.s_valid[i] = 1'b1;
            bus.s_data[i]  = srcq[i][0].data;
            bus.s_last[i]  = srcq[i][0].last;
         end else begin
            if (stall_left[i] > 0) stall_left[i]--;
            bus.s_valid[i] = 1'b0;
            bus.s_data[i]  = $urandom;
            bus.s_last[i]  = 1'($urandom);
         end
      end
      acc = '0;
   endtask

   task automatic run_traffic(input string name, input logic lane_first, input logic lane_rest,
                              input bit toggle);
      exp_t  exp_q [$];
      exp_t  e;
      word_t copyq [N][$];
      word_t w;
      int    fl [N];
      int    ptr, pick, frame_no, rat, exp_under, exp_vcyc;
      int    cyc, phase, gap, under, vcyc, started;
      bit    in_frame, had_frame, beat_last, first_last_seen, done, new_beat;
      logic  cur_valid, cur_last, lane_exp;
      logic [31:0] cur_data;
      logic [N-1:0] gmask;

      // Reference: frames leave in round-robin order over requesters with frames pending.
      exp_under = 0; exp_vcyc = 0; frame_no = 0; ptr = model_ptr;
      for (int i = 0; i < N; i++) begin
         copyq[i] = srcq[i];
         fl[i] = 0;
         for (int k = 0; k < srcq[i].size(); k++) if (srcq[i][k].last) fl[i]++;
      end
      forever begin
         pick = -1;
         for (int k = N; k >= 1; k--) if (fl[(ptr + k) % N] > 0) pick = (ptr + k) % N;
         if (pick < 0) break;
         fl[pick]--;
         e.lane = (frame_no == 0) ? lane_first : lane_rest;
         rat = e.lane ? R_SINGLE : R_MULTI;
         do begin
            w = copyq[pick].pop_front();
            e.src = pick; e.data = w.data; e.last = w.last;
            exp_q.push_back(e);
            exp_under += w.stall / rat;
            exp_vcyc  += rat;
         end while (!w.last);
         ptr = pick;
         frame_no++;
      end
      model_ptr = ptr;

      single_lane_in = lane_first;
      acc = '0;
      for (int i = 0; i < N; i++) stall_left[i] = 0;
      drive();
      cyc = 0; phase = 0; gap = 0; under = 0; vcyc = 0; started = 0; rat = R_MULTI;
      in_frame = 0; had_frame = 0; beat_last = 0; first_last_seen = 0;
      cur_valid = 0; cur_last = 0; cur_data = '0; lane_exp = 0;
      done = (exp_q.size() == 0);
      while (!done && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         new_beat = 0;
         gmask = '0;
         gmask[grant_id] = 1'b1;
         n_cmp++;
         if ((bus.s_ready & ~gmask) !== '0 || (bus.s_ready !== '0 && busy !== 1'b1)) begin
            n_fail++;
            $display("FAIL %s s_ready: got %b (grant_id=%0d busy=%b), required at most bit %0d while busy",
                     name, bus.s_ready, grant_id, busy, grant_id);
         end
         acc = bus.s_ready & bus.s_valid;
         if (axi_valid === 1'b1) vcyc++;
         if (!in_frame) begin
            if (axi_valid === 1'b1) begin
               if (had_frame) begin
                  n_cmp++;
                  if (gap < IFG + 1) begin
                     n_fail++;
                     $display("FAIL %s gap: got %0d idle cycles, required >= %0d", name, gap, IFG + 1);
                  end
               end
               in_frame = 1; phase = 0; started++; new_beat = 1;
            end else begin
               gap++;
            end
         end else begin
            phase = (phase + 1) % rat;
            if (phase == 0) begin
               if (beat_last) begin
                  n_cmp++;
                  if (axi_valid !== 1'b0) begin
                     n_fail++;
                     $display("FAIL %s frame_end: got axi_valid=%b, required 0", name, axi_valid);
                  end
                  in_frame = 0; had_frame = 1; gap = 1;
                  done = (exp_q.size() == 0);
               end else if (axi_valid === 1'b1) begin
                  new_beat = 1;
               end else begin
                  under++;
                  cur_valid = 0; cur_last = 0; cur_data = '0;
               end
            end else begin
               n_cmp++;
               if ({axi_valid, axi_last, axi_data, single_lane} !==
                   {cur_valid, cur_last, cur_data, lane_exp}) begin
                  n_fail++;
                  $display("FAIL %s beat_hold: got v=%b l=%b d=%h sl=%b, required v=%b l=%b d=%h sl=%b",
                           name, axi_valid, axi_last, axi_data, single_lane,
                           cur_valid, cur_last, cur_data, lane_exp);
               end
            end
         end
         if (new_beat) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL %s extra_beat: got data=%h from %0d, required no further beats",
                        name, axi_data, grant_id);
            end else begin
               e = exp_q.pop_front();
               if (grant_id !== 2'(e.src) || axi_data !== e.data || axi_last !== e.last ||
                   single_lane !== e.lane) begin
                  n_fail++;
                  $display("FAIL %s beat: got src=%0d d=%h l=%b sl=%b, required src=%0d d=%h l=%b sl=%b",
                           name, grant_id, axi_data, axi_last, single_lane,
                           e.src, e.data, e.last, e.lane);
               end
               rat = e.lane ? R_SINGLE : R_MULTI;
               cur_valid = 1; cur_data = e.data; cur_last = e.last;
               beat_last = e.last; lane_exp = e.lane;
               if (started == 1 && e.last) first_last_seen = 1;
            end
         end
         if (!done) begin
            @(posedge clk);
            #1;
            if (toggle) begin
               if (first_last_seen) single_lane_in = lane_rest;
               else if (in_frame && started == 1) single_lane_in = 1'($urandom);
            end
            drive();
         end
      end
      acc = '0;
      n_cmp++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s timeout: got %0d beats outstanding after %0d cycles, required 0",
                  name, exp_q.size(), cyc);
      end
      n_cmp++;
      if (under != exp_under) begin
         n_fail++;
         $display("FAIL %s underruns: got %0d, required %0d", name, under, exp_under);
      end
      n_cmp++;
      if (vcyc != exp_vcyc) begin
         n_fail++;
         $display("FAIL %s valid_cycles: got %0d, required %0d", name, vcyc, exp_vcyc);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.s_valid = '0;
      bus.s_last  = '0;
      for (int i = 0; i < N; i++) bus.s_data[i] = '0;
      #2;
      n_cmp++;
      if ({axi_valid, axi_last, axi_data, single_lane, grant_id, busy, bus.s_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_during: got v=%b l=%b d=%h sl=%b g=%0d busy=%b rdy=%b, required all 0",
                  axi_valid, axi_last, axi_data, single_lane, grant_id, busy, bus.s_ready);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_ptr = N - 1;
      @(negedge clk);
      n_cmp++;
      if ({axi_valid, axi_last, axi_data, single_lane, grant_id, busy, bus.s_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_after: got v=%b l=%b d=%h sl=%b g=%0d busy=%b rdy=%b, required all 0",
                  axi_valid, axi_last, axi_data, single_lane, grant_id, busy, bus.s_ready);
      end
   endtask

   task automatic test_single_frame();
      add_frame(0, 3, 0, 0);
      run_traffic("single_frame", 1'b0, 1'b0, 1'b0);
      for (int k = 1; k < IFG; k++) begin
         @(negedge clk);
         n_cmp++;
         if (axi_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ifg_hold: cycle %0d got v=%b busy=%b, required v=0 busy=1",
                     k, axi_valid, busy);
         end
      end
      @(negedge clk);
      n_cmp++;
      if (axi_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL ifg_end: got v=%b busy=%b, required v=0 busy=0", axi_valid, busy);
      end
   endtask

   task automatic test_two_req();
      apply_reset();
      add_frame(1, 2, 0, 0);
      add_frame(1, 3, 0, 0);
      add_frame(3, 2, 0, 0);
      run_traffic("two_req", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_underrun();
      add_frame(2, 4, 2, R_MULTI);
      run_traffic("underrun", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_lane_switch();
      add_frame(1, 3, 0, 0);
      add_frame(1, 2, 0, 0);
      run_traffic("lane_switch", 1'b0, 1'b1, 1'b1);
   endtask

   task automatic test_back_to_back();
      apply_reset();
      for (int r = 0; r < N; r++) add_frame(r, 2, 0, 0);
      add_frame(0, 2, 0, 0);
      run_traffic("back_to_back", 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      int cyc;
      logic [31:0] d0, d2;
      d0 = 32'hA0A0_0001;
      d2 = 32'hC2C2_0002;
      single_lane_in = 1'b0;
      bus.s_valid = 4'b0100;
      bus.s_data[2] = d2;
      bus.s_last[2] = 1'b0;
      cyc = 0;
      @(negedge clk);
      while (axi_valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (axi_valid !== 1'b1 || grant_id !== 2'd2) begin
         n_fail++;
         $display("FAIL reset_mid_start: got v=%b g=%0d, required v=1 g=2", axi_valid, grant_id);
      end
      repeat (R_MULTI) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      n_cmp++;
      if ({axi_valid, axi_last, axi_data, single_lane, grant_id, busy, bus.s_ready} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_async: got v=%b l=%b d=%h sl=%b g=%0d busy=%b rdy=%b, required all 0",
                  axi_valid, axi_last, axi_data, single_lane, grant_id, busy, bus.s_ready);
      end
      bus.s_valid = 4'b0101;
      bus.s_data[0] = d0;
      bus.s_last[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cyc = 0;
      while (axi_valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
      n_cmp++;
      if (axi_valid !== 1'b1 || grant_id !== 2'd0 || axi_data !== d0) begin
         n_fail++;
         $display("FAIL reset_mid_regrant: got v=%b g=%0d d=%h, required v=1 g=0 d=%h",
                  axi_valid, grant_id, axi_data, d0);
      end
      apply_reset();
   endtask

   task automatic test_random();
      int nf, nw, total;
      logic lane;
      for (int round = 0; round < 4; round++) begin
         total = 0;
         for (int r = 0; r < N; r++) begin
            nf = $urandom_range(0, 3);
            if (round == 0 && r == 0 && nf == 0) nf = 1;
            for (int f = 0; f < nf; f++) begin
               nw = $urandom_range(1, 5);
               add_frame(r, nw, (nw > 1) ? $urandom_range(1, nw - 1) : 0, $urandom_range(0, 5));
               total++;
            end
         end
         if (total == 0) add_frame($urandom_range(0, N - 1), 2, 0, 0);
         lane = 1'($urandom);
         run_traffic("random", lane, lane, 1'b0);
      end
   endtask

   initial begin
      bus.s_valid = '0;
      bus.s_last  = '0;
      acc = '0;
      model_ptr = N - 1;
      #2;
      test_reset();
      test_single_frame();
      test_two_req();
      test_underrun();
      test_lane_switch();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
